rgb2hsv_pipe: RTL and testbench

Parametrised, fully pipelined RGB→HSV converter for the video path, used ahead of skin-colour segmentation.
- Accepts one pixel per enabled clock.
- Delays hsync/vsync/de to match the pixel latency.
- Fixed latency with clock-enable stall.
- Blanks outputs outside active video.
- Asynchronous active-low reset.

---
 rtl/rgb2hsv_pkg.sv | 32 +++
 rtl/hsv_div_pipe.sv | 95 +++++++++
 rtl/rgb2hsv_pipe.sv | 140 ++++++++++++++
 tb/tb_rgb2hsv_pipe.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/rgb2hsv_pkg.sv
// Shared widths, sector encoding and latency helpers for the RGB->HSV pipeline.
package rgb2hsv_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_H_W     = 8;
  localparam int DEF_S_W     = 8;
  localparam int DEF_HUE_SEC = 42;

  // Sector index; hue base is sector * HUE_SEC.
  localparam logic [2:0] SEC_R0 = 3'd0;
  localparam logic [2:0] SEC_R1 = 3'd1;
  localparam logic [2:0] SEC_R2 = 3'd2;
  localparam logic [2:0] SEC_R3 = 3'd3;
  localparam logic [2:0] SEC_R4 = 3'd4;
  localparam logic [2:0] SEC_R5 = 3'd5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int div_stages(input int h_w, input int s_w);
    return (h_w > s_w) ? h_w : s_w;
  endfunction

  function automatic int calc_lat(input int h_w, input int s_w);
    return div_stages(h_w, s_w) + 3;
  endfunction

endpackage

// File: rtl/hsv_div_pipe.sv
// Pipelined restoring divider, one quotient bit per stage, trailing delay stages
// pad the result to STAGES; a side-band tag travels with each operand pair.
module hsv_div_pipe #(
  parameter int NUM_W  = 16,
  parameter int DEN_W  = 8,
  parameter int Q_W    = 8,
  parameter int TAG_W  = 1,
  parameter int STAGES = Q_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  input  logic [TAG_W-1:0] i_tag,
  output logic [Q_W-1:0]   o_q,
  output logic [TAG_W-1:0] o_tag
);

  // Wide enough for the divisor shifted by the top quotient bit.
  localparam int CMP_W = (NUM_W > DEN_W + Q_W) ? NUM_W : DEN_W + Q_W;

  logic [CMP_W-1:0] r_rem [Q_W-1];
  logic [DEN_W-1:0] r_den [Q_W-1];
  logic [Q_W-1:0]   r_q   [STAGES];
  logic [TAG_W-1:0] r_tag [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi < Q_W) begin : g_div
        localparam int SH = Q_W - 1 - gi;
        logic [CMP_W-1:0] w_rem_in;
        logic [CMP_W-1:0] w_den_sh;
        logic [DEN_W-1:0] w_den_in;
        logic [Q_W-1:0]   w_q_in;
        logic             w_ge;

        if (gi == 0) begin : g_first
          assign w_rem_in = CMP_W'(i_num);
          assign w_den_in = i_den;
          assign w_q_in   = '0;
        end else begin : g_next
          assign w_rem_in = r_rem[gi-1];
          assign w_den_in = r_den[gi-1];
          assign w_q_in   = r_q[gi-1];
        end

        assign w_den_sh = CMP_W'(w_den_in) << SH;
        assign w_ge     = (w_rem_in >= w_den_sh);

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_q[gi] <= '0;
          end else if (ce) begin
            r_q[gi] <= w_ge ? (w_q_in | (Q_W'(1) << SH)) : w_q_in;
          end
        end

        // The last quotient stage has no consumer for its remainder.
        if (gi < Q_W - 1) begin : g_carry
          always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
              r_rem[gi] <= '0;
              r_den[gi] <= '0;
            end else if (ce) begin
              r_rem[gi] <= w_ge ? (w_rem_in - w_den_sh) : w_rem_in;
              r_den[gi] <= w_den_in;
            end
          end
        end
      end else begin : g_delay
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_q[gi] <= '0;
          end else if (ce) begin
            r_q[gi] <= r_q[gi-1];
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_tag[gi] <= '0;
        end else if (ce) begin
          r_tag[gi] <= (gi == 0) ? i_tag : r_tag[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign o_q   = r_q[STAGES-1];
  assign o_tag = r_tag[STAGES-1];

endmodule

// File: rtl/rgb2hsv_pipe.sv
// Fully pipelined RGB->HSV converter with matched sync delay, clock-enable
// stall and blanking outside active video.
module rgb2hsv_pipe
  import rgb2hsv_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int H_W     = DEF_H_W,
  parameter int S_W     = DEF_S_W,
  parameter int HUE_SEC = DEF_HUE_SEC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [DATA_W-1:0] R,
  input  logic [DATA_W-1:0] G,
  input  logic [DATA_W-1:0] B,
  input  logic              in_hsync,
  input  logic              in_vsync,
  input  logic              in_de,
  output logic [H_W-1:0]    H,
  output logic [S_W-1:0]    S,
  output logic [DATA_W-1:0] V,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_de
);

  localparam int LAT        = calc_lat(H_W, S_W);
  localparam int DIV_STAGES = LAT - 3;
  localparam int HQ_W       = clog2(HUE_SEC + 1);
  localparam int HN_W       = DATA_W + HQ_W;
  localparam int SN_W       = DATA_W + S_W;
  localparam int S_FULL     = (1 << S_W) - 1;
  localparam int TAG_W      = 1 + 3 + DATA_W + 3;

  logic [DATA_W-1:0] r1_r, r1_g, r1_b;
  logic              r1_hs, r1_vs, r1_de;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r1_r, r1_g, r1_b, r1_hs, r1_vs, r1_de} <= '0;
    end else if (ce) begin
      {r1_r, r1_g, r1_b, r1_hs, r1_vs, r1_de} <= {R, G, B, in_hsync, in_vsync, in_de};
    end
  end

  logic [DATA_W-1:0] w_max, w_min, w_num, w_d;
  logic [2:0]        w_sec;

  // Ties resolve toward R, then G, so every pixel maps to exactly one sector.
  always_comb begin
    w_max = r1_b;
    w_min = r1_r;
    w_sec = SEC_R0;
    w_num = '0;
    if (r1_r >= r1_g && r1_r >= r1_b) begin
      w_max = r1_r;
      if (r1_g >= r1_b) begin
        w_sec = SEC_R0; w_num = r1_g - r1_b; w_min = r1_b;
      end else begin
        w_sec = SEC_R5; w_num = r1_r - r1_b; w_min = r1_g;
      end
    end else if (r1_g >= r1_b) begin
      w_max = r1_g;
      if (r1_r >= r1_b) begin
        w_sec = SEC_R1; w_num = r1_g - r1_r; w_min = r1_b;
      end else begin
        w_sec = SEC_R2; w_num = r1_b - r1_r; w_min = r1_r;
      end
    end else begin
      w_max = r1_b;
      if (r1_g >= r1_r) begin
        w_sec = SEC_R3; w_num = r1_b - r1_g; w_min = r1_r;
      end else begin
        w_sec = SEC_R4; w_num = r1_r - r1_g; w_min = r1_g;
      end
    end
    w_d = w_max - w_min;
  end

  logic [HN_W-1:0]   r2_hnum;
  logic [SN_W-1:0]   r2_snum;
  logic [DATA_W-1:0] r2_d, r2_max;
  logic [TAG_W-1:0]  r2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r2_hnum, r2_snum, r2_d, r2_max, r2_tag} <= '0;
    end else if (ce) begin
      r2_hnum <= HN_W'(w_num) * HN_W'(HUE_SEC);
      r2_snum <= SN_W'(w_d) * SN_W'(S_FULL);
      r2_d    <= w_d;
      r2_max  <= w_max;
      r2_tag  <= {(w_d == '0), w_sec, w_max, r1_hs, r1_vs, r1_de};
    end
  end

  logic [HQ_W-1:0]  w_hq;
  logic [S_W-1:0]   w_sq;
  logic [TAG_W-1:0] w_tag;
  logic             w_s_zero;

  hsv_div_pipe #(
    .NUM_W(HN_W), .DEN_W(DATA_W), .Q_W(HQ_W), .TAG_W(TAG_W), .STAGES(DIV_STAGES)
  ) u_hue_div (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .i_num(r2_hnum), .i_den(r2_d), .i_tag(r2_tag),
    .o_q(w_hq), .o_tag(w_tag)
  );

  hsv_div_pipe #(
    .NUM_W(SN_W), .DEN_W(DATA_W), .Q_W(S_W), .TAG_W(1), .STAGES(DIV_STAGES)
  ) u_sat_div (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .i_num(r2_snum), .i_den(r2_max), .i_tag(r2_tag[TAG_W-1]),
    .o_q(w_sq), .o_tag(w_s_zero)
  );

  logic              w_zero, w_hs, w_vs, w_de;
  logic [2:0]        w_osec;
  logic [DATA_W-1:0] w_v;
  logic [H_W-1:0]    w_h;

  assign {w_zero, w_osec, w_v, w_hs, w_vs, w_de} = w_tag;
  assign w_h = H_W'(w_osec) * H_W'(HUE_SEC) + H_W'(w_hq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {H, S, V, out_hsync, out_vsync, out_de} <= '0;
    end else if (ce) begin
      out_hsync <= w_hs;
      out_vsync <= w_vs;
      out_de    <= w_de;
      H         <= (w_de && !w_zero)   ? w_h  : '0;
      S         <= (w_de && !w_s_zero) ? w_sq : '0;
      V         <= w_de ? w_v : '0;
    end
  end

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Randomised self-checking bench for rgb2hsv_pipe against a behavioural HSV model.
module tb_rgb2hsv_pipe;

  localparam int LAT = 11;
  localparam int HS  = 42;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic hs, vs, de;
  } pix_t;

  typedef struct packed {
    logic [7:0] h, s, v;
    logic hs, vs, de;
  } out_t;

  logic clk = 0, rst_n = 0, ce = 0;
  logic [7:0] R = 0, G = 0, B = 0;
  logic in_hsync = 0, in_vsync = 0, in_de = 0;
  logic [7:0] H, S, V;
  logic out_hsync, out_vsync, out_de;

  int checks = 0, errors = 0;
  pix_t hist[$];

  always #5 clk = ~clk;

  rgb2hsv_pipe dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .R(R), .G(G), .B(B),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .H(H), .S(S), .V(V),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de)
  );

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Continuous hue: sixths of a turn scaled by HS, wrapped into 0..6*HS-1.
  function automatic out_t model(input pix_t p);
    out_t o;
    int r, g, b, mx, mn, d, hx, h;
    r = p.r; g = p.g; b = p.b;
    mx = r; if (g > mx) mx = g; if (b > mx) mx = b;
    mn = r; if (g < mn) mn = g; if (b < mn) mn = b;
    d = mx - mn;
    o = '0;
    o.hs = p.hs; o.vs = p.vs; o.de = p.de;
    if (!p.de) return o;
    o.v = 8'(mx);
    if (d == 0) return o;
    if (r >= g && r >= b)  hx = HS * (g - b);
    else if (g >= b)       hx = HS * (2 * d + b - r);
    else                   hx = HS * (4 * d + r - g);
    h = floor_div(hx, d);
    if (h < 0) h = h + 6 * HS;
    o.h = 8'(h);
    o.s = 8'((d * 255) / mx);
    return o;
  endfunction

  function automatic pix_t mkpix(input int r, input int g, input int b, input logic de);
    pix_t p;
    p.r = 8'(r); p.g = 8'(g); p.b = 8'(b);
    p.hs = 1'b0; p.vs = 1'b0; p.de = de;
    return p;
  endfunction

  task automatic pin_model(input string name, input pix_t p, input int h, input int s, input int v);
    out_t o;
    o = model(p);
    checks++;
    if (o.h !== 8'(h) || o.s !== 8'(s) || o.v !== 8'(v)) begin
      errors++;
      $display("FAIL model_%s: got H=%0d S=%0d V=%0d, want H=%0d S=%0d V=%0d",
               name, o.h, o.s, o.v, h, s, v);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && ce) hist.push_back({R, G, B, in_hsync, in_vsync, in_de});
  end

  always @(negedge rst_n) hist.delete();

  always @(negedge clk) begin
    out_t exp_o, act_o;
    int n;
    n = hist.size();
    exp_o = '0;
    if (rst_n && n >= LAT) exp_o = model(hist[n - LAT]);
    act_o = {H, S, V, out_hsync, out_vsync, out_de};
    checks++;
    if (act_o !== exp_o) begin
      errors++;
      $display("FAIL pipe_out t=%0t: got H=%0d S=%0d V=%0d hs=%b vs=%b de=%b, want H=%0d S=%0d V=%0d hs=%b vs=%b de=%b",
               $time, act_o.h, act_o.s, act_o.v, act_o.hs, act_o.vs, act_o.de,
               exp_o.h, exp_o.s, exp_o.v, exp_o.hs, exp_o.vs, exp_o.de);
    end else begin
      $display("cycle t=%0t ce=%b H=%0d S=%0d V=%0d hs=%b vs=%b de=%b",
               $time, ce, act_o.h, act_o.s, act_o.v, act_o.hs, act_o.vs, act_o.de);
    end
  end

  task automatic step(input pix_t p, input logic c);
    @(posedge clk);
    #2;
    R = p.r; G = p.g; B = p.b;
    in_hsync = p.hs; in_vsync = p.vs; in_de = p.de;
    ce = c;
  endtask

  function automatic pix_t rand_pix();
    pix_t p;
    p.r = 8'($urandom_range(0, 255));
    p.g = 8'($urandom_range(0, 255));
    p.b = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 7) == 0) p.g = p.r;
    p.hs = 1'($urandom_range(0, 1));
    p.vs = 1'($urandom_range(0, 1));
    p.de = ($urandom_range(0, 4) != 0);
    return p;
  endfunction

  initial begin
    pix_t dir[$];
    pix_t p;
    int enabled;

    pin_model("pink",   mkpix(101, 100, 101, 1), 210, 2,   101);
    pin_model("red",    mkpix(192, 100,  98, 1), 0,   124, 192);
    pin_model("green",  mkpix(0,   255,   0, 1), 84,  255, 255);
    pin_model("blue",   mkpix(0,     0, 255, 1), 168, 255, 255);
    pin_model("grey",   mkpix(50,   50,  50, 1), 0,   0,   50);
    pin_model("black",  mkpix(0,     0,   0, 1), 0,   0,   0);
    pin_model("blank",  mkpix(192, 100,  98, 0), 0,   0,   0);

    repeat (3) @(posedge clk);
    #2 rst_n = 1;

    dir.push_back(mkpix(101, 100, 101, 1));
    dir.push_back(mkpix(192, 100,  98, 1));
    dir.push_back(mkpix(0,   255,   0, 1));
    dir.push_back(mkpix(0,     0, 255, 1));
    dir.push_back(mkpix(50,   50,  50, 1));
    dir.push_back(mkpix(0,     0,   0, 1));
    dir.push_back(mkpix(192, 100,  98, 0));
    dir[1].hs = 1'b1;
    dir[3].vs = 1'b1;
    foreach (dir[i]) step(dir[i], 1'b1);
    for (int i = 0; i < LAT + 2; i++) step(mkpix(0, 0, 0, 0), 1'b1);

    enabled = 0;
    while (enabled < 20) begin
      if ($urandom_range(0, 2) != 0) begin
        p = rand_pix();
        step(p, 1'b1);
        enabled++;
      end else begin
        step(rand_pix(), 1'b0);
      end
    end
    for (int i = 0; i < 60; i++) step(rand_pix(), 1'($urandom_range(0, 3) != 0));

    @(posedge clk);
    #3 rst_n = 0;
    #1;
    checks++;
    if ({H, S, V, out_hsync, out_vsync, out_de} !== '0) begin
      errors++;
      $display("FAIL async_reset: got H=%0d S=%0d V=%0d hs=%b vs=%b de=%b, want all 0",
               H, S, V, out_hsync, out_vsync, out_de);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    for (int i = 0; i < 40; i++) step(rand_pix(), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < LAT + 4; i++) step(mkpix(0, 0, 0, 0), 1'b1);
    @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
